// File: rtl/hilo_mdu_if.sv
// HI/LO write-side interface between EX issue logic and the multiply/divide unit.
interface hilo_mdu_if #(
    parameter int DW = 32
);
    logic              op_valid;
    logic [2:0]        op;
    logic [DW-1:0]     src1;
    logic [DW-1:0]     src2;
    logic              flush;
    logic              stallreq;
    logic              busy;
    logic [2*DW+1:0]   hilo_bus;

    modport master (
        output op_valid, op, src1, src2, flush,
        input  stallreq, busy, hilo_bus
    );

    modport slave (
        input  op_valid, op, src1, src2, flush,
        output stallreq, busy, hilo_bus
    );
endinterface

// File: rtl/hilo_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit plus MTHI/MTLO, driving the 66-bit HI/LO write bus.
//
// state | meaning
// IDLE  | waiting; accepts mult/div (to BUSY) or issues MTHI/MTLO pulse
// BUSY  | one shift-add or restoring subtract-shift step per cycle
// DONE  | sign fix, register the HI/LO write, instruction leaves EX
module hilo_mdu #(
    parameter int ITER = 32,
    parameter int DW   = 32
) (
    input  logic       clk,
    input  logic       rst,
    hilo_mdu_if.slave  mdu
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [DW-1:0]     r_b;
    logic [2*DW-1:0]   r_p;
    logic              r_is_div;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_dz;
    logic              r_busy;
    logic [2*DW+1:0]   r_hilo;

    logic              w_accept;
    logic              w_is_div;
    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [DW-1:0]     w_a_mag;
    logic [DW-1:0]     w_b_mag;
    logic [DW:0]       w_mul_sum;
    logic [2*DW-1:0]   w_mul_next;
    logic [DW:0]       w_div_shift;
    logic [DW-1:0]     w_div_rem;
    logic [2*DW-1:0]   w_div_next;
    logic [2*DW-1:0]   w_prod;
    logic [DW-1:0]     w_quo;
    logic [DW-1:0]     w_rem;
    logic [2*DW-1:0]   w_result;

    assign w_accept = (r_state == S_IDLE) && mdu.op_valid && !mdu.flush && (mdu.op <= 3'd3);
    assign w_is_div = mdu.op[1];
    assign w_signed = !mdu.op[0];
    assign w_a_neg  = w_signed && mdu.src1[DW-1];
    assign w_b_neg  = w_signed && mdu.src2[DW-1];
    assign w_a_mag  = w_a_neg ? -mdu.src1 : mdu.src1;
    assign w_b_mag  = w_b_neg ? -mdu.src2 : mdu.src2;

    // Multiply: r_p = {partial high, remaining multiplier bits}, shifted right each step.
    assign w_mul_sum  = {1'b0, r_p[2*DW-1:DW]} + {1'b0, (r_p[0] ? r_b : {DW{1'b0}})};
    assign w_mul_next = {w_mul_sum, r_p[DW-1:1]};

    // Divide: r_p = {remainder, dividend/quotient}; a successful trial shifts in a 1.
    assign w_div_shift = {r_p[2*DW-1:DW], r_p[DW-1]};
    assign w_div_rem   = w_div_shift[DW-1:0] - r_b;
    assign w_div_next  = (w_div_shift >= {1'b0, r_b}) ? {w_div_rem, r_p[DW-2:0], 1'b1}
                                                      : {w_div_shift[DW-1:0], r_p[DW-2:0], 1'b0};

    assign w_prod   = r_neg_q ? -r_p : r_p;
    assign w_quo    = r_dz ? {DW{1'b1}} : (r_neg_q ? -r_p[DW-1:0] : r_p[DW-1:0]);
    assign w_rem    = r_neg_r ? -r_p[2*DW-1:DW] : r_p[2*DW-1:DW];
    assign w_result = r_is_div ? {w_rem, w_quo} : w_prod;

    assign mdu.stallreq = w_accept || ((r_state == S_BUSY) && !mdu.flush);
    assign mdu.busy     = r_busy;
    assign mdu.hilo_bus = r_hilo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_b      <= '0;
            r_p      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_busy   <= 1'b0;
            r_hilo   <= '0;
        end else begin
            r_hilo <= '0;
            r_busy <= 1'b0;
            if (mdu.flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_state  <= S_BUSY;
                            r_busy   <= 1'b1;
                            r_cnt    <= '0;
                            r_is_div <= w_is_div;
                            r_b      <= w_is_div ? w_b_mag : w_a_mag;
                            r_p      <= {{DW{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_is_div && w_a_neg;
                            r_dz     <= w_is_div && (mdu.src2 == '0);
                        end else if (mdu.op_valid && mdu.op == 3'd4) begin
                            r_hilo <= {2'b10, mdu.src1, {DW{1'b0}}};
                        end else if (mdu.op_valid && mdu.op == 3'd5) begin
                            r_hilo <= {2'b01, {DW{1'b0}}, mdu.src1};
                        end
                    end
                    S_BUSY: begin
                        r_p   <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(ITER - 1)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_busy <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_hilo  <= {2'b11, w_result};
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: per-cycle timeline model plus literal result checks.
module tb_hilo_mdu;
    localparam int NC = 2048;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   seen = 0;
    int   stall_cnt = 0;
    logic [65:0] last_bus = '0;

    bit [65:0] exp_bus[NC];
    bit        exp_stall[NC];
    bit        exp_busy[NC];

    hilo_mdu_if mif();

    hilo_mdu dut (
        .clk (clk),
        .rst (rst),
        .mdu (mif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    // Reference results from plain 64-bit arithmetic; returns {HI, LO}.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        p = '0;
        case (op)
            3'd0: begin q = sa * sb; p = q; end
            3'd1: p = {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
            end
            3'd3: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    always @(negedge clk) begin
        if (cyc < NC) begin
            check("stallreq", {65'b0, mif.stallreq}, {65'b0, exp_stall[cyc]});
            check("busy", {65'b0, mif.busy}, {65'b0, exp_busy[cyc]});
            check("hilo_bus", mif.hilo_bus, exp_bus[cyc]);
        end
        if (mif.hilo_bus[65:64] != 2'b00) begin
            last_bus = mif.hilo_bus;
            seen++;
        end
        if (mif.stallreq) stall_cnt++;
        if (rst && mif.op_valid && mif.busy) begin
            n_fail++;
            $display("FAIL op_valid_while_busy @cycle %0d: got 1 expected 0", cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
        int t;
        t = cyc;
        mif.op_valid = 1'b1;
        mif.op       = op;
        mif.src1     = a;
        mif.src2     = b;
        mif.flush    = fl;
        if (!fl) begin
            if (op <= 3'd3) begin
                for (int k = t; k <= t + 32; k++) exp_stall[k] = 1'b1;
                for (int k = t + 1; k <= t + 32; k++) exp_busy[k] = 1'b1;
                exp_bus[t + 34] = {2'b11, model(op, a, b)};
            end else if (op == 3'd4) begin
                exp_bus[t + 1] = {2'b10, a, 32'b0};
            end else if (op == 3'd5) begin
                exp_bus[t + 1] = {2'b01, 32'b0, a};
            end
        end
        tick();
        mif.op_valid = 1'b0;
        mif.flush    = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [65:0] lit);
        int s0;
        s0 = seen;
        issue(op, a, b, 1'b0);
        for (int i = 0; i < 45 && seen == s0; i++) tick();
        check(name, (seen != s0) ? last_bus : 66'b0, lit);
        tick();
        tick();
    endtask

    initial begin
        int s0;
        int t;
        rst = 1'b0;
        mif.op_valid = 1'b0;
        mif.op = 3'd0;
        mif.src1 = '0;
        mif.src2 = '0;
        mif.flush = 1'b0;
        repeat (3) tick();
        check("reset_bus", mif.hilo_bus, 66'b0);
        check("reset_flags", {64'b0, mif.stallreq, mif.busy}, 66'b0);
        rst = 1'b1;
        repeat (2) tick();

        stall_cnt = 0;
        run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, {2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        check("mult_stall_cycles", 66'(stall_cnt), 66'd33);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {2'b11, 32'hFFFF_FFFE, 32'h0000_0001});
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, {2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, {2'b11, 32'd2, 32'd14});
        run_op("divu_by_zero", 3'd3, 32'd5, 32'd0, {2'b11, 32'd5, 32'hFFFF_FFFF});
        run_op("div_by_zero", 3'd2, 32'hFFFF_FFF0, 32'd0, {2'b11, 32'hFFFF_FFF0, 32'hFFFF_FFFF});
        run_op("div_overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {2'b11, 32'h0, 32'h8000_0000});
        run_op("mult_mixed", 3'd0, 32'h0001_0000, 32'hFFFF_0000, {2'b11, 32'hFFFF_FFFF, 32'h0000_0000});

        stall_cnt = 0;
        run_op("mthi", 3'd4, 32'h1234_5678, 32'h0, {2'b10, 32'h1234_5678, 32'h0});
        run_op("mtlo", 3'd5, 32'h9ABC_DEF0, 32'h0, {2'b01, 32'h0, 32'h9ABC_DEF0});
        check("mt_no_stall", 66'(stall_cnt), 66'd0);

        // flush beats op_valid; ops 6/7 do nothing
        s0 = seen;
        stall_cnt = 0;
        issue(3'd0, 32'd7, 32'd9, 1'b1);
        issue(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b1);
        issue(3'd6, 32'd1, 32'd2, 1'b0);
        issue(3'd7, 32'd3, 32'd4, 1'b0);
        repeat (40) tick();
        check("ignored_no_write", 66'(seen - s0), 66'd0);
        check("ignored_no_stall", 66'(stall_cnt), 66'd0);

        // flush in BUSY cycle 10
        s0 = seen;
        t = cyc;
        issue(3'd2, 32'd1000, 32'd3, 1'b0);
        repeat (9) tick();
        mif.flush = 1'b1;
        for (int k = t + 10; k < t + 40; k++) exp_stall[k] = 1'b0;
        for (int k = t + 11; k < t + 40; k++) begin exp_busy[k] = 1'b0; exp_bus[k] = '0; end
        tick();
        mif.flush = 1'b0;
        repeat (40) tick();
        check("flush_no_write", 66'(seen - s0), 66'd0);

        // reset in BUSY cycle 10
        s0 = seen;
        t = cyc;
        issue(3'd2, 32'd1000, 32'd3, 1'b0);
        repeat (9) tick();
        rst = 1'b0;
        for (int k = t + 10; k < t + 40; k++) begin
            exp_stall[k] = 1'b0; exp_busy[k] = 1'b0; exp_bus[k] = '0;
        end
        #1;
        check("rst_abort_bus", mif.hilo_bus, 66'b0);
        check("rst_abort_flags", {64'b0, mif.stallreq, mif.busy}, 66'b0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (40) tick();
        check("rst_no_write", 66'(seen - s0), 66'd0);

        run_op("after_reset_divu", 3'd3, 32'hFFFF_FFFF, 32'd16, {2'b11, 32'd15, 32'h0FFF_FFFF});

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
